// File: rtl/led_pio_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// No waitrequest; readdata is returned one cycle after the address.
interface led_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_out.sv
// LED output PIO: data register with set/clear ports, per-bit blink mask and period prescaler.
// Writes land on out_port one edge after the strobe, reads have 1-cycle latency; never stalls the bus.
module led_pio_out #(
  parameter int                    DATA_WIDTH   = 18,
  parameter int                    PERIOD_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  led_pio_out_if.slave          bus,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   out_d;
  logic [31:0]             rd_mux;
  logic                    wr;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic                    unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd_data   = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:     data_d   = wd_data;
        ADDR_MASK:     mask_d   = wd_data;
        ADDR_PERIOD:   period_d = bus.writedata[PERIOD_WIDTH-1:0];
        ADDR_OUTSET:   data_d   = data_q | wd_data;
        ADDR_OUTCLEAR: data_d   = data_q & ~wd_data;
        default:       ;
      endcase
    end
  end

  // A PERIOD write restarts the prescaler so the first toggle lands on the next cycle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr && bus.address == ADDR_PERIOD) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q - PERIOD_WIDTH'(1);
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PERIOD_WIDTH'(1);
    end
  end

  assign out_d = data_d & ~(mask_d & {DATA_WIDTH{phase_d}});

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:   rd_mux = 32'(data_q);
      ADDR_MASK:   rd_mux = 32'(mask_q);
      ADDR_PERIOD: rd_mux = 32'(period_q);
      ADDR_STATUS: rd_mux = {31'd0, phase_q};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= RESET_VALUE;
      mask_q       <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      out_port     <= RESET_VALUE;
      bus.readdata <= '0;
    end else begin
      data_q       <= data_d;
      mask_q       <= mask_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      out_port     <= out_d;
      bus.readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_led_pio_out.sv
// Bench for led_pio_out: queued expectations from a cycle-count model, checked by a per-edge monitor.
// Directed scenarios first, then randomized bus traffic.
module tb_led_pio_out;

  logic        clk;
  logic        reset;
  logic [17:0] out_port;

  led_pio_out_if bus();

  led_pio_out #(.DATA_WIDTH(18), .PERIOD_WIDTH(24), .RESET_VALUE(18'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] op;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  // Reference state: the phase is derived from cycles elapsed since the last PERIOD write.
  logic [17:0] m_data, m_mask;
  logic [23:0] m_per;
  int          m_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_phase(input logic [23:0] p, input int k);
    if (p == 0 || k == 0) return 1'b0;
    return 1'(((k - 1) / int'(p) + 1) % 2);
  endfunction

  task automatic model_reset();
    m_data = 18'h0;
    m_mask = 18'h0;
    m_per  = 24'h0;
    m_k    = 0;
  endtask

  // Drive one bus cycle and queue what the DUT should show after the following edge.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    exp_t e;
    logic ph;
    @(negedge clk);
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    ph = m_phase(m_per, m_k);
    case (a)
      3'd0:    e.rd = {14'd0, m_data};
      3'd1:    e.rd = {14'd0, m_mask};
      3'd2:    e.rd = {8'd0, m_per};
      3'd3:    e.rd = {31'd0, ph};
      default: e.rd = 32'd0;
    endcase
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = wd[17:0];
        3'd1: m_mask = wd[17:0];
        3'd2: m_per  = wd[23:0];
        3'd4: m_data = m_data | wd[17:0];
        3'd5: m_data = m_data & ~wd[17:0];
        default: ;
      endcase
    end
    if (cs && !wn && a == 3'd2) m_k = 0;
    else m_k++;
    ph = m_phase(m_per, m_k);
    e.op = m_data & ~(m_mask & {18{ph}});
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("sb_out_port@%0d", edge_no), {14'd0, out_port}, {14'd0, e.op});
        chk($sformatf("sb_readdata@%0d", edge_no), bus.readdata, e.rd);
      end
    end
  end

  initial begin : stim
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    model_reset();
    #3;
    chk("reset_out_port", {14'd0, out_port}, 32'd0);
    chk("reset_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    step(1, 0, 3'd0, 32'h0002_AAAA);
    settle();
    chk("data_write_out", {14'd0, out_port}, 32'h0002_AAAA);
    step(1, 1, 3'd0, 32'h0);
    settle();
    chk("data_read", bus.readdata, 32'h0002_AAAA);

    step(1, 0, 3'd0, 32'h0000_00F0);
    step(1, 0, 3'd4, 32'h0000_000F);
    step(1, 1, 3'd0, 32'h0);
    settle();
    chk("outset_data", bus.readdata, 32'h0000_00FF);
    step(1, 0, 3'd5, 32'h0000_0030);
    step(1, 1, 3'd0, 32'h0);
    settle();
    chk("outclear_data", bus.readdata, 32'h0000_00CF);
    step(1, 1, 3'd4, 32'h0);
    settle();
    chk("outset_reads_zero", bus.readdata, 32'h0);
    step(1, 1, 3'd5, 32'h0);
    settle();
    chk("outclear_reads_zero", bus.readdata, 32'h0);

    // Asynchronous reset landing mid-cycle while a write is pending.
    step(1, 1, 3'd0, 32'h0);
    settle();
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'h0003_FFFF;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_port", {14'd0, out_port}, 32'd0);
    chk("async_reset_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    reset          = 1'b0;
    model_reset();
    step(1, 1, 3'd0, 32'h0);
    settle();
    chk("post_reset_data", bus.readdata, 32'h0);

    step(1, 0, 3'd0, 32'h0003_FFFF);
    step(1, 0, 3'd1, 32'h0000_0003);
    step(1, 0, 3'd2, 32'd4);
    settle();
    chk("blink_start_out", {14'd0, out_port}, 32'h0003_FFFF);
    step(0, 1, 3'd3, 32'h0);
    settle();
    chk("blink_phase1_out", {14'd0, out_port}, 32'h0003_FFFC);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd3, 32'h0);
    settle();
    chk("blink_phase0_out", {14'd0, out_port}, 32'h0003_FFFF);
    chk("status_phase1", bus.readdata, 32'h1);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd3, 32'h0);
    settle();
    chk("blink_again_out", {14'd0, out_port}, 32'h0003_FFFC);

    step(1, 0, 3'd2, 32'd0);
    settle();
    chk("period0_out", {14'd0, out_port}, 32'h0003_FFFF);
    for (int i = 0; i < 10; i++) step(0, 1, 3'd3, 32'h0);
    settle();
    chk("period0_no_toggle", {14'd0, out_port}, 32'h0003_FFFF);
    chk("period0_status", bus.readdata, 32'h0);
    step(1, 0, 3'd6, 32'hFFFF_FFFF);
    step(1, 0, 3'd7, 32'hFFFF_FFFF);
    step(1, 1, 3'd6, 32'h0);
    settle();
    chk("reserved_reads_zero", bus.readdata, 32'h0);
    step(1, 1, 3'd0, 32'h0);
    settle();
    chk("reserved_keeps_data", bus.readdata, 32'h0003_FFFF);
    step(1, 1, 3'd1, 32'h0);
    settle();
    chk("reserved_keeps_mask", bus.readdata, 32'h0000_0003);
    step(1, 1, 3'd2, 32'h0);
    settle();
    chk("reserved_keeps_period", bus.readdata, 32'h0);

    step(0, 0, 3'd0, 32'h0001_2345);
    step(0, 0, 3'd0, 32'h0001_2345);
    settle();
    chk("no_cs_keeps_data", bus.readdata, 32'h0003_FFFF);
    chk("no_cs_out_port", {14'd0, out_port}, 32'h0003_FFFF);

    for (int i = 0; i < 500; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, wd);
    end

    settle();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
